sub_byte_iter: RTL

//  Iterative AES SubBytes engine for the next-gen datapath. Applies the AES forward S-box to

---
 rtl/sub_byte_iter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sub_byte_iter.sv
// ----------------------------------------------------------------------------
// sub_byte_iter: iterative AES SubBytes engine, LANES S-boxes per pass. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] s
);
  // Entry 0 sits in the most significant byte, so the index is inverted.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] idx_n;

  assign idx_n = ~{x, y};
  assign s     = SBOX_TABLE[{idx_n, 3'b000} +: 8];
endmodule

module sub_byte_iter #(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_data,
  output logic                     busy
);
  localparam int PASSES = BLOCK_BYTES / LANES;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [8*BLOCK_BYTES-1:0] buf_q, buf_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               lane_in  [LANES];
  logic [7:0]               lane_out [LANES];

  // Byte 0 is the leftmost (most significant) byte of the bus.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = buf_q[8*(BLOCK_BYTES-1-(int'(cnt_q)*LANES+l)) +: 8];

    sbox u_sbox (
      .x (lane_in[l][7:4]),
      .y (lane_in[l][3:0]),
      .s (lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_d   = in_data;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            buf_d[8*(BLOCK_BYTES-1-(int'(cnt_q)*LANES+l)) +: 8] = lane_out[l];
          end
          if (cnt_q == CW'(PASSES-1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              buf_d   = in_data;
              cnt_d   = '0;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush cycle must never complete a handshake on either side.
  assign in_ready  = rst_n && !flush &&
                     ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = (state_q == DONE) && !flush;
  assign out_data  = out_valid ? buf_q : '0;
  assign busy      = (state_q == RUN) || (state_q == DONE);
endmodule

`default_nettype wire
